text_buf_arbiter: RTL and testbench
===================================

TEXT_BUF_ARBITER -- requirements
Module: text_buf_arbiter

Interface
REQ-001 Parameter ADDR_W, 11, character-buffer address width (40x30 = 1200 cells).
REQ-002 Parameter DATA_W, 8, character code width.
REQ-003 Parameter MAX_WAIT, 64, host wait-cycle limit before starvation flag.
REQ-004 CLK  in  1  single system clock; all logic on rising edge.
REQ-005 RST_n  in  1  reset, synchronous, active-low.
REQ-006 disp_req  in  1  display character-fetch request, one-cycle pulse.
REQ-007 disp_addr  in  ADDR_W  display fetch address, valid with disp_req.
REQ-008 disp_valid  out  1  display data valid pulse.
REQ-009 disp_data  out  DATA_W  fetched character code, valid with disp_valid.
REQ-010 host_req  in  1  host access request, level, held until host_ack.
REQ-011 host_we  in  1  host write (1) / read (0), stable while host_req.
REQ-012 host_addr  in  ADDR_W  host address, stable while host_req.
REQ-013 host_wdata  in  DATA_W  host write data, stable while host_req.
REQ-014 host_ack  out  1  host completion pulse, one cycle.
REQ-015 host_rdata  out  DATA_W  host read data, valid with host_ack on reads.
REQ-016 host_starved  out  1  sticky flag: host waited > MAX_WAIT cycles.
REQ-017 mem_en, mem_we  out  1 each  synchronous RAM enable / write enable.
REQ-018 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  (RAM read latency 1 cycle).

Function
REQ-019 disp_req sampled at edge N -> mem_en=1, mem_we=0, mem_addr=disp_addr during cycle N+1; disp_valid=1 with disp_data=mem_rdata registered in cycle N+3; fixed latency 3, never stalled.
REQ-020 Display has absolute priority: display accepted every cycle it requests, including back-to-back.
REQ-021 Host FSM states: H_IDLE, H_ISSUE, H_WAIT, H_ACK.
REQ-022 H_IDLE -> H_ISSUE when host_req=1 and no disp_req sampled at the same edge; otherwise remain H_IDLE and increment wait counter.
REQ-023 H_ISSUE (one cycle): mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata; -> H_WAIT.
REQ-024 H_WAIT (one cycle): capture mem_rdata into host_rdata on reads; -> H_ACK.
REQ-025 H_ACK (one cycle): host_ack=1; -> H_IDLE; host_req sampled in H_ACK ignored (host drops it after ack).
REQ-026 Display request arriving while host in H_WAIT/H_ACK proceeds normally; only one RAM access per cycle is possible since H_ISSUE is entered only in cycles with no display slot.
REQ-027 host_rdata holds last read value until next host read; writes leave it unchanged.
REQ-028 Wait counter: counts cycles in H_IDLE with host_req=1, cleared on entry to H_ISSUE; saturates at MAX_WAIT+1; host_starved set when count exceeds MAX_WAIT, cleared only by reset.
REQ-029 Same-address host write and display read in adjacent cycles: display returns pre-write data if its RAM cycle precedes the write, post-write data otherwise; no forwarding.
REQ-030 mem_en=0 in any cycle without a granted access; mem_we=0 whenever mem_en=0.

Reset
REQ-031 RST_n=0 at an edge: FSM -> H_IDLE, display pipeline flushed, wait counter=0.
REQ-032 Reset outputs: disp_valid=0, disp_data=0, host_ack=0, host_rdata=0, host_starved=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset mid-access: in-flight display fetch and host access discarded, no ack or valid issued; host re-requests after reset.

Structure
REQ-034 Shared package holds host FSM state encoding and ADDR_W/DATA_W defaults; shared with the text-display top.
REQ-035 One sub-module natural: disp_fetch_pipe (3-stage display request/valid pipeline).

Verification
REQ-036 Reset 20 cycles, release; disp_req addr 0x005 with RAM[5]=0x41 -> mem_en at N+1, disp_valid with 0x41 at N+3.
REQ-037 Host write addr 0x123 data 0x5A, no display traffic -> mem_we pulse 1 cycle after sample, host_ack 2 cycles later; subsequent host read returns 0x5A.
REQ-038 disp_req every cycle for 100 cycles with host_req held -> no host grant, host_starved=1 after cycle 65, host granted first idle cycle.
REQ-039 disp_req every second cycle with host reads pending -> host served in gaps, display latency always 3, never two mem_en accesses in one cycle.
REQ-040 Assert RST_n=0 during H_WAIT -> no host_ack, all outputs at reset values next cycle.

Source files
------------

// File: rtl/text_buf_arbiter_pkg.sv
// Shared definitions for the text-display character buffer: host FSM encoding
// and default buffer geometry.
package text_buf_arbiter_pkg;

  localparam int ADDR_W_DEF   = 11;
  localparam int DATA_W_DEF   = 8;
  localparam int MAX_WAIT_DEF = 64;

  typedef enum logic [1:0] {
    H_IDLE  = 2'd0,
    H_ISSUE = 2'd1,
    H_WAIT  = 2'd2,
    H_ACK   = 2'd3
  } host_state_e;

endpackage

// File: rtl/text_buf_arbiter_disp_fetch_pipe.sv
// Display fetch tracker: follows each display request through the one-cycle
// RAM read and registers the returned character three cycles after the request.
module text_buf_arbiter_disp_fetch_pipe
  import text_buf_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              disp_req,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data
);

  logic              s1_r;
  logic              s2_r;
  logic              valid_r;
  logic [DATA_W-1:0] data_r;

  // s1 marks the RAM access cycle, s2 the cycle the RAM data is on mem_rdata
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
    end else begin
      s1_r    <= disp_req;
      s2_r    <= s1_r;
      valid_r <= s2_r;
      if (s2_r) begin
        data_r <= mem_rdata;
      end
    end
  end

  assign disp_valid = valid_r;
  assign disp_data  = data_r;

endmodule

// File: rtl/text_buf_arbiter.sv
// Character-buffer RAM arbiter: display fetches take every slot they ask for,
// the host is served in free slots and flags starvation when kept waiting.
module text_buf_arbiter
  import text_buf_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_starved,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                CNT_W = $clog2(MAX_WAIT + 2);
  localparam logic [CNT_W-1:0]  SAT_C = CNT_W'(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  LIM_C = CNT_W'(MAX_WAIT);

  host_state_e       state_r, state_nxt_s;
  logic              grant_s;
  logic [CNT_W-1:0]  wait_r, wait_nxt_s;
  logic              starved_r;
  logic              op_we_r;
  logic              host_ack_r;
  logic [DATA_W-1:0] host_rdata_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  // Host FSM next state; a grant only happens in a slot with no display request
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    wait_nxt_s  = wait_r;
    case (state_r)
      H_IDLE: begin
        if (host_req && !disp_req) begin
          grant_s     = 1'b1;
          state_nxt_s = H_ISSUE;
          wait_nxt_s  = {CNT_W{1'b0}};
        end else if (host_req) begin
          wait_nxt_s = (wait_r == SAT_C) ? SAT_C : wait_r + CNT_W'(1);
        end else begin
          wait_nxt_s = wait_r;
        end
      end
      H_ISSUE: state_nxt_s = H_WAIT;
      H_WAIT:  state_nxt_s = H_ACK;
      H_ACK:   state_nxt_s = H_IDLE;
      default: state_nxt_s = H_IDLE;
    endcase
  end

  // State, wait counter, host handshake and RAM port registers
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_r      <= H_IDLE;
      wait_r       <= {CNT_W{1'b0}};
      starved_r    <= 1'b0;
      op_we_r      <= 1'b0;
      host_ack_r   <= 1'b0;
      host_rdata_r <= {DATA_W{1'b0}};
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_r     <= wait_nxt_s;
      starved_r  <= starved_r | (wait_nxt_s > LIM_C);
      host_ack_r <= (state_r == H_WAIT);
      if (grant_s) begin
        op_we_r <= host_we;
      end
      if (state_r == H_WAIT && !op_we_r) begin
        host_rdata_r <= mem_rdata;
      end
      mem_en_r <= disp_req | grant_s;
      mem_we_r <= grant_s & host_we;
      if (disp_req) begin
        mem_addr_r <= disp_addr;
      end else if (grant_s) begin
        mem_addr_r  <= host_addr;
        mem_wdata_r <= host_wdata;
      end
    end
  end

  text_buf_arbiter_disp_fetch_pipe #(
    .DATA_W (DATA_W)
  ) u_disp_pipe (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .disp_req   (disp_req),
    .mem_rdata  (mem_rdata),
    .disp_valid (disp_valid),
    .disp_data  (disp_data)
  );

  assign host_ack     = host_ack_r;
  assign host_rdata   = host_rdata_r;
  assign host_starved = starved_r;
  assign mem_en       = mem_en_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;

endmodule

// File: tb/tb_text_buf_arbiter.sv
// Directed bench for text_buf_arbiter with a behavioural 1-cycle-latency RAM.
module tb_text_buf_arbiter;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        disp_req;
  logic [10:0] disp_addr;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        host_req;
  logic        host_we;
  logic [10:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_starved;
  logic        mem_en;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  logic [7:0]  ram [0:2047];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  text_buf_arbiter dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_valid   (disp_valid),
    .disp_data    (disp_data),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ack     (host_ack),
    .host_rdata   (host_rdata),
    .host_starved (host_starved),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // RAM model; preset contents are loaded while reset is held
  always @(posedge CLK) begin
    if (!RST_n) begin
      ram[11'h005] <= 8'h41;
      ram[11'h010] <= 8'h33;
      ram[11'h200] <= 8'h77;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " disp_valid"},   16'(disp_valid),   16'h0);
    chk({tag, " disp_data"},    16'(disp_data),    16'h0);
    chk({tag, " host_ack"},     16'(host_ack),     16'h0);
    chk({tag, " host_rdata"},   16'(host_rdata),   16'h0);
    chk({tag, " host_starved"}, 16'(host_starved), 16'h0);
    chk({tag, " mem_en"},       16'(mem_en),       16'h0);
    chk({tag, " mem_we"},       16'(mem_we),       16'h0);
    chk({tag, " mem_addr"},     16'(mem_addr),     16'h0);
    chk({tag, " mem_wdata"},    16'(mem_wdata),    16'h0);
  endtask

  logic       alt_disp  [0:5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       alt_en    [0:5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [10:0] alt_addr [0:5] = '{11'h010, 11'h200, 11'h010, 11'h000, 11'h010, 11'h000};
  logic       alt_ack   [0:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       alt_valid [0:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    RST_n = 1'b0; disp_req = 1'b0; disp_addr = 11'h000;
    host_req = 1'b0; host_we = 1'b0; host_addr = 11'h000; host_wdata = 8'h00;
    for (int i = 0; i < 20; i++) tick();
    chk_reset_outputs("reset");
    RST_n = 1'b1;
    tick();

    // display fetch of address 5
    disp_req = 1'b1; disp_addr = 11'h005;
    tick();
    disp_req = 1'b0;
    chk("disp n+1 mem_en", 16'(mem_en), 16'h1);
    chk("disp n+1 mem_we", 16'(mem_we), 16'h0);
    chk("disp n+1 mem_addr", 16'(mem_addr), 16'h005);
    tick();
    chk("disp n+2 valid", 16'(disp_valid), 16'h0);
    chk("disp n+2 mem_en", 16'(mem_en), 16'h0);
    tick();
    chk("disp n+3 valid", 16'(disp_valid), 16'h1);
    chk("disp n+3 data", 16'(disp_data), 16'h41);
    tick();
    chk("disp n+4 valid", 16'(disp_valid), 16'h0);

    // host write 0x123 <- 0x5A
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h123; host_wdata = 8'h5A;
    tick();
    chk("hw issue mem_en", 16'(mem_en), 16'h1);
    chk("hw issue mem_we", 16'(mem_we), 16'h1);
    chk("hw issue mem_addr", 16'(mem_addr), 16'h123);
    chk("hw issue mem_wdata", 16'(mem_wdata), 16'h5A);
    chk("hw issue ack", 16'(host_ack), 16'h0);
    tick();
    chk("hw wait mem_en", 16'(mem_en), 16'h0);
    chk("hw wait ack", 16'(host_ack), 16'h0);
    tick();
    chk("hw ack", 16'(host_ack), 16'h1);
    chk("hw rdata unchanged", 16'(host_rdata), 16'h00);
    host_req = 1'b0;
    tick();
    chk("hw ack drop", 16'(host_ack), 16'h0);

    // host read 0x123
    host_req = 1'b1; host_we = 1'b0;
    tick();
    chk("hr issue mem_en", 16'(mem_en), 16'h1);
    chk("hr issue mem_we", 16'(mem_we), 16'h0);
    tick();
    tick();
    chk("hr ack", 16'(host_ack), 16'h1);
    chk("hr rdata", 16'(host_rdata), 16'h5A);
    host_req = 1'b0;
    tick();
    tick();

    // display flood with host read of address 5 pending
    disp_req = 1'b1; disp_addr = 11'h005;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h005;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk("flood mem_en", 16'(mem_en), 16'h1);
      chk("flood mem_we", 16'(mem_we), 16'h0);
      chk("flood no ack", 16'(host_ack), 16'h0);
      if (k >= 3) chk("flood disp_data", {7'(0), disp_valid, disp_data}, 16'h0141);
      if (k == 64) chk("flood starved@64", 16'(host_starved), 16'h0);
      if (k == 65) chk("flood starved@65", 16'(host_starved), 16'h1);
    end
    disp_req = 1'b0;
    tick();
    chk("grant mem_en", 16'(mem_en), 16'h1);
    chk("grant mem_we", 16'(mem_we), 16'h0);
    chk("grant mem_addr", 16'(mem_addr), 16'h005);
    tick();
    tick();
    chk("grant ack", 16'(host_ack), 16'h1);
    chk("grant rdata", 16'(host_rdata), 16'h41);
    chk("starved sticky", 16'(host_starved), 16'h1);
    host_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // alternating display slots with a host read of 0x200 pending
    disp_addr = 11'h010; host_req = 1'b1; host_we = 1'b0; host_addr = 11'h200;
    for (int i = 0; i < 6; i++) begin
      disp_req = alt_disp[i];
      if (i == 4) host_req = 1'b0;
      tick();
      chk("alt mem_en", 16'(mem_en), 16'(alt_en[i]));
      if (alt_en[i]) chk("alt mem_addr", 16'(mem_addr), 16'(alt_addr[i]));
      chk("alt mem_we", 16'(mem_we), 16'h0);
      chk("alt ack", 16'(host_ack), 16'(alt_ack[i]));
      chk("alt valid", 16'(disp_valid), 16'(alt_valid[i]));
      if (alt_valid[i]) chk("alt disp_data", 16'(disp_data), 16'h33);
      if (alt_ack[i]) chk("alt rdata", 16'(host_rdata), 16'h77);
    end
    disp_req = 1'b0;
    tick();
    tick();

    // reset while host write is in H_WAIT with a display fetch in flight
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h300; host_wdata = 8'h99;
    tick();
    chk("rst issue mem_we", 16'(mem_we), 16'h1);
    disp_req = 1'b1; disp_addr = 11'h005;
    tick();
    disp_req = 1'b0;
    RST_n = 1'b0;
    host_req = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    tick();
    RST_n = 1'b1;
    chk("midrst hold ack", 16'(host_ack), 16'h0);
    chk("midrst hold valid", 16'(disp_valid), 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post rst ack", 16'(host_ack), 16'h0);
      chk("post rst valid", 16'(disp_valid), 16'h0);
      chk("post rst mem_en", 16'(mem_en), 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
